rf_write_arbiter: RTL and testbench
===================================

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter: NREQ, 4, number of writeback requesters (fixed at 4 in this revision).
REQ-002 Parameter: DW, 16, register data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 req_i  input  NREQ  per-requester write request; held until acked.
REQ-006 addr_i  input  3*NREQ  destination register index per requester (slice i = bits 3i+2:3i).
REQ-007 data_i  input  DW*NREQ  write data per requester (slice i = bits DWi+DW-1:DWi).
REQ-008 hold_i  input  1  register file busy; when 1, no grant is issued.
REQ-009 ack_o  output  NREQ  one-hot, one-cycle pulse: requester's write performed this cycle.
REQ-010 rf_we_o  output  8  one-hot register write enables (decoded address); all-zero when idle.
REQ-011 rf_addr_o  output  3  registered destination index of current write.
REQ-012 rf_data_o  output  DW  registered write data of current write.
REQ-013 busy_o  output  1  1 whenever any req_i is pending and not acked this cycle.

Function
REQ-014 Arbitration is round-robin over eligible requesters, starting search at index ptr (2-bit pointer), ascending, wrapping 3->0.
REQ-015 Eligible = req_i[i]=1 AND hold_i=0 AND NOT (ack_o[i]=1 this cycle).
REQ-016 Winner at edge T: addr/data of winner registered into rf_addr_o/rf_data_o; rf_we_o = decode(winner addr) and ack_o = onehot(winner) in cycle T+1 (latency 1).
REQ-017 No eligible requester at edge T: rf_we_o, ack_o all-zero in T+1; rf_addr_o/rf_data_o retain last values.
REQ-018 After a grant to index w, ptr <= (w+1) mod 4; ptr unchanged when no grant.
REQ-019 At most one bit of ack_o and one bit of rf_we_o set in any cycle; ack_o and rf_we_o nonzero in exactly the same cycles.
REQ-020 Requester sees ack_o[i] and drops req_i, or presents new addr/data, on the following cycle; the REQ-015 mask prevents a double write of stale data.
REQ-021 Back-to-back grants: with continuous eligible requests, one write per cycle (except REQ-015 masking of a sole requester -> at most one write every 2 cycles).
REQ-022 hold_i=1 at edge T: no grant; rf_we_o=0 in T+1; a write already shown in cycle T completes unaffected.
REQ-023 req_i dropped before ack: request silently withdrawn, no write.
REQ-024 Controller state: IDLE (no write output) and WRITE (rf_we_o active); IDLE->WRITE on grant, WRITE->WRITE on grant, WRITE->IDLE on no grant.

Reset
REQ-025 reset_n=0 asynchronously forces: ptr=0, state=IDLE, ack_o=0, rf_we_o=0, rf_addr_o=0, rf_data_o=0.
REQ-026 Reset asserted mid-write aborts the write immediately (rf_we_o drops without clock); no ack issued for it.
REQ-027 First grant possible at first rising edge after reset_n deasserts.

Structure
REQ-028 Shared package lca_pkg holds NREQ, DW, REG_CNT=8, and state encoding (IDLE=0, WRITE=1).
REQ-029 Address-to-enable decode uses existing decode8 as the single sub-module, fed by rf_addr_o and gated by state==WRITE.
REQ-030 Priority search is combinational; all outputs except busy_o are registered.

Verification
REQ-031 Reset: reset_n=0 with all req_i=1 -> ack_o=0, rf_we_o=8'h00; release -> cycle T+1 ack_o=4'b0001.
REQ-032 Single write: req_i=4'b0100, addr=5, data=16'hBEEF -> next cycle rf_we_o=8'h20, rf_data_o=16'hBEEF, ack_o=4'b0100.
REQ-033 Round-robin: req_i=4'b1111 held, new data each ack -> ack order 0,1,2,3,0 on consecutive cycles, no gaps.
REQ-034 Sole requester held: req_i=4'b0010 constant -> ack_o pulses every 2nd cycle, never two consecutive.
REQ-035 Hold: req_i=4'b1000, hold_i=1 for 3 cycles -> rf_we_o=0 throughout; first ack 1 cycle after hold_i falls.
REQ-036 Mid-write reset: assert reset_n=0 during rf_we_o active -> rf_we_o=0 same cycle, ptr=0 after release.

Source files
------------

// File: rtl/lca_pkg.sv
// Shared constants, controller state encoding and small helpers for the
// register-file writeback arbiter.
package lca_pkg;

    localparam int NREQ    = 4;
    localparam int DW      = 16;
    localparam int REG_CNT = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    // One-hot encoding of a 2-bit requester index.
    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        onehot4 = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/decode8.sv
// 3-to-8 one-hot decoder with enable; drives the register-file write enables.
module decode8
    import lca_pkg::*;
(
    input  logic               en,
    input  logic [2:0]         addr,
    output logic [REG_CNT-1:0] dec
);

    // Decode the register index; all-zero while disabled.
    always_comb begin
        dec = {REG_CNT{1'b0}};
        if (en) begin
            dec[addr] = 1'b1;
        end else begin
            dec = {REG_CNT{1'b0}};
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin writeback arbiter: picks one of NREQ requesters per cycle and
// presents its register index/data to the register file one cycle later.
// A requester acked in the current cycle is masked so its stale request is
// not written twice while it updates or drops req_i.
module rf_write_arbiter
    import lca_pkg::*;
#(
    parameter int NREQ = lca_pkg::NREQ,
    parameter int DW   = lca_pkg::DW
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NREQ-1:0]     req_i,
    input  logic [3*NREQ-1:0]   addr_i,
    input  logic [DW*NREQ-1:0]  data_i,
    input  logic                hold_i,
    output logic [NREQ-1:0]     ack_o,
    output logic [REG_CNT-1:0]  rf_we_o,
    output logic [2:0]          rf_addr_o,
    output logic [DW-1:0]       rf_data_o,
    output logic                busy_o
);

    localparam int PW = $clog2(NREQ);

    state_t          state_r;
    logic [PW-1:0]   ptr_r;
    logic [NREQ-1:0] ack_r;
    logic [2:0]      addr_r;
    logic [DW-1:0]   data_r;

    logic [NREQ-1:0] elig_s;
    logic            grant_s;
    logic [PW-1:0]   win_s;
    logic [2:0]      win_addr_s;
    logic [DW-1:0]   win_data_s;

    // Eligible requesters: requesting, register file free, not acked this cycle.
    always_comb begin
        elig_s = {NREQ{1'b0}};
        if (hold_i) begin
            elig_s = {NREQ{1'b0}};
        end else begin
            elig_s = req_i & ~ack_r;
        end
    end

    // Round-robin search from ptr upward; lowest offset from ptr wins.
    always_comb begin
        grant_s = 1'b0;
        win_s   = ptr_r;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (elig_s[ptr_r + PW'(k)]) begin
                grant_s = 1'b1;
                win_s   = ptr_r + PW'(k);
            end else begin
                grant_s = grant_s;
                win_s   = win_s;
            end
        end
    end

    // Select the winning requester's register index and data.
    always_comb begin
        win_addr_s = 3'd0;
        win_data_s = {DW{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            if (win_s == PW'(i)) begin
                win_addr_s = addr_i[3*i +: 3];
                win_data_s = data_i[DW*i +: DW];
            end else begin
                win_addr_s = win_addr_s;
                win_data_s = win_data_s;
            end
        end
    end

    // Controller FSM with registered ack, write address/data and pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            ptr_r   <= {PW{1'b0}};
            ack_r   <= {NREQ{1'b0}};
            addr_r  <= 3'd0;
            data_r  <= {DW{1'b0}};
        end else begin
            case (state_r)
                IDLE:    state_r <= grant_s ? WRITE : IDLE;
                WRITE:   state_r <= grant_s ? WRITE : IDLE;
                default: state_r <= IDLE;
            endcase
            if (grant_s) begin
                ack_r  <= onehot4(win_s);
                addr_r <= win_addr_s;
                data_r <= win_data_s;
                ptr_r  <= win_s + PW'(1);
            end else begin
                ack_r  <= {NREQ{1'b0}};
                addr_r <= addr_r;
                data_r <= data_r;
                ptr_r  <= ptr_r;
            end
        end
    end

    decode8 u_decode8 (
        .en   (state_r == WRITE),
        .addr (addr_r),
        .dec  (rf_we_o)
    );

    assign ack_o     = ack_r;
    assign rf_addr_o = addr_r;
    assign rf_data_o = data_r;
    assign busy_o    = |(req_i & ~ack_r);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed corner sequences, a
// vector table, and randomized traffic against a behavioural model.
module tb_rf_write_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 16;

    logic        clk;
    logic        reset_n;
    logic [3:0]  req_i;
    logic [11:0] addr_i;
    logic [63:0] data_i;
    logic        hold_i;
    logic [3:0]  ack_o;
    logic [7:0]  rf_we_o;
    logic [2:0]  rf_addr_o;
    logic [15:0] rf_data_o;
    logic        busy_o;

    int total;
    int bad;

    typedef struct {
        logic [3:0]  req;
        logic        hold;
        logic [2:0]  addr;
        logic [15:0] data;
        logic [3:0]  e_ack;
        logic [7:0]  e_we;
        logic [15:0] e_data;
    } vec_t;

    vec_t tbl [8];

    rf_write_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_i     (req_i),
        .addr_i    (addr_i),
        .data_i    (data_i),
        .hold_i    (hold_i),
        .ack_o     (ack_o),
        .rf_we_o   (rf_we_o),
        .rf_addr_o (rf_addr_o),
        .rf_data_o (rf_data_o),
        .busy_o    (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        req_i   = 4'b0000;
        hold_i  = 1'b0;
        tick();
        chk("rst_ack", ack_o, 32'h0);
        chk("rst_we", rf_we_o, 32'h0);
        chk("rst_addr", rf_addr_o, 32'h0);
        chk("rst_data", rf_data_o, 32'h0);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [3:0] rr_ack [5];
        int   m_ptr;
        int   m_ack;
        logic [2:0]  m_addr;
        logic [15:0] m_data;

        total = 0;
        bad   = 0;

        // Reset with every requester active, then round-robin order.
        reset_n = 1'b0;
        hold_i  = 1'b0;
        req_i   = 4'b1111;
        addr_i  = {3'd7, 3'd6, 3'd5, 3'd4};
        data_i  = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
        tick();
        chk("reset_ack", ack_o, 32'h0);
        chk("reset_we", rf_we_o, 32'h0);
        tick();
        chk("reset_ack2", ack_o, 32'h0);
        reset_n = 1'b1;
        rr_ack = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int c = 0; c < 5; c++) begin
            int idx;
            idx = (c == 4) ? 0 : c;
            data_i = {16'h3300 + 16'(c), 16'h2200 + 16'(c), 16'h1100 + 16'(c), 16'h0000 + 16'(c)};
            tick();
            chk("rr_ack", ack_o, 32'(rr_ack[c]));
            chk("rr_we", rf_we_o, 32'(8'b1 << (idx + 4)));
            chk("rr_data", rf_data_o, 32'(16'h1100 * idx + c));
        end

        // Sole requester held: ack every second cycle.
        req_i = 4'b0000;
        tick();
        chk("idle_ack", ack_o, 32'h0);
        req_i = 4'b0010;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("sole_ack", ack_o, (c % 2 == 0) ? 32'h2 : 32'h0);
        end

        // Hold for three cycles, ack one cycle after hold falls.
        req_i = 4'b0000;
        tick();
        req_i  = 4'b1000;
        hold_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("hold_we", rf_we_o, 32'h0);
            chk("hold_ack", ack_o, 32'h0);
        end
        hold_i = 1'b0;
        tick();
        chk("hold_rel_ack", ack_o, 32'h8);
        chk("hold_rel_we", rf_we_o, 32'h80);
        req_i = 4'b0000;
        tick();

        // Reset asserted while a write is shown.
        addr_i = {3'd0, 3'd3, 3'd0, 3'd0};
        req_i  = 4'b0100;
        tick();
        chk("mw_we", rf_we_o, 32'h08);
        chk("mw_ack", ack_o, 32'h4);
        req_i = 4'b0000;
        #3;
        reset_n = 1'b0;
        #1;
        chk("mw_we_drop", rf_we_o, 32'h0);
        chk("mw_ack_drop", ack_o, 32'h0);
        tick();
        reset_n = 1'b1;
        req_i   = 4'b1111;
        addr_i  = {3'd7, 3'd6, 3'd5, 3'd4};
        tick();
        chk("mw_ptr0_ack", ack_o, 32'h1);
        req_i = 4'b0000;
        tick();

        // Vector table, starting from reset.
        tbl[0] = '{4'b0100, 1'b0, 3'd5, 16'hBEEF, 4'b0100, 8'h20, 16'hBEEF};
        tbl[1] = '{4'b0000, 1'b0, 3'd0, 16'h0000, 4'b0000, 8'h00, 16'hBEEF};
        tbl[2] = '{4'b0001, 1'b1, 3'd2, 16'h1234, 4'b0000, 8'h00, 16'hBEEF};
        tbl[3] = '{4'b0001, 1'b0, 3'd2, 16'h1234, 4'b0001, 8'h04, 16'h1234};
        tbl[4] = '{4'b1001, 1'b0, 3'd7, 16'h5555, 4'b1000, 8'h80, 16'h5555};
        tbl[5] = '{4'b0011, 1'b0, 3'd0, 16'h0A0A, 4'b0001, 8'h01, 16'h0A0A};
        tbl[6] = '{4'b0011, 1'b0, 3'd1, 16'h7777, 4'b0010, 8'h02, 16'h7777};
        tbl[7] = '{4'b0000, 1'b0, 3'd0, 16'h0000, 4'b0000, 8'h00, 16'h7777};
        apply_reset();
        for (int v = 0; v < 8; v++) begin
            req_i  = tbl[v].req;
            hold_i = tbl[v].hold;
            addr_i = {4{tbl[v].addr}};
            data_i = {4{tbl[v].data}};
            tick();
            chk("tbl_ack", ack_o, 32'(tbl[v].e_ack));
            chk("tbl_we", rf_we_o, 32'(tbl[v].e_we));
            chk("tbl_data", rf_data_o, 32'(tbl[v].e_data));
        end

        // Randomized traffic against the behavioural model.
        apply_reset();
        m_ptr  = 0;
        m_ack  = -1;
        m_addr = 3'd0;
        m_data = 16'h0;
        for (int c = 0; c < 400; c++) begin
            int w;
            logic [3:0]  ackmask;
            logic [31:0] exp_we;
            req_i  = 4'($urandom_range(0, 15));
            hold_i = ($urandom_range(0, 4) == 0);
            addr_i = 12'($urandom);
            data_i = {$urandom, $urandom};
            #1;
            ackmask = (m_ack >= 0) ? (4'b0001 << m_ack) : 4'b0000;
            chk("rnd_busy", 32'(busy_o), 32'(|(req_i & ~ackmask)));
            w = -1;
            if (!hold_i) begin
                for (int k = 0; k < 4; k++) begin
                    int i;
                    i = (m_ptr + k) % 4;
                    if (w < 0 && req_i[i] && i != m_ack) w = i;
                end
            end
            if (w >= 0) begin
                m_addr = addr_i[3*w +: 3];
                m_data = data_i[16*w +: 16];
                m_ptr  = (w + 1) % 4;
            end
            m_ack = w;
            @(posedge clk);
            #1;
            exp_we = (m_ack >= 0) ? (32'h1 << m_addr) : 32'h0;
            chk("rnd_ack", ack_o, (m_ack >= 0) ? (32'h1 << m_ack) : 32'h0);
            chk("rnd_we", rf_we_o, exp_we);
            chk("rnd_addr", rf_addr_o, 32'(m_addr));
            chk("rnd_data", rf_data_o, 32'(m_data));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
